// File: rtl/hazard_perf_monitor_if.sv
// Counter read port of the hazard performance monitor: one-cycle request, one-cycle response.
// The debug side drives the request (master); the monitor answers it (slave).
interface hazard_perf_monitor_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             RdReq;
  logic [2:0]       RdSel;
  logic [CNT_W-1:0] RdData;
  logic             RdValid;

  modport master (
    output RdReq,
    output RdSel,
    input  RdData,
    input  RdValid
  );

  modport slave (
    input  RdReq,
    input  RdSel,
    output RdData,
    output RdValid
  );

endinterface

// File: rtl/hazard_perf_monitor.sv
// Passive event counters for the pipeline hazard unit: eight saturating counters, a sticky
// per-counter overflow flag, an IDLE/RUN/HALT control FSM and a single-request read port.
module hazard_perf_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_OVF = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Enable,
  input  logic                        Clear,
  input  logic                        StallF,
  input  logic                        StallD,
  input  logic                        FlushD,
  input  logic                        FlushE,
  input  logic                        BranchTakenE,
  input  logic [1:0]                  ForwardAE,
  input  logic [1:0]                  ForwardBE,
  hazard_perf_monitor_if.slave        rd,
  output logic [7:0]                  Overflow,
  output logic                        Running
);

  localparam int unsigned NumCnt = 8;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  state_e            state_q;
  logic              running_q;

  logic [CNT_W-1:0]  cnt_q   [NumCnt];
  logic [CNT_W-1:0]  cnt_d   [NumCnt];
  logic [CNT_W:0]    sum     [NumCnt];
  logic [1:0]        inc     [NumCnt];
  logic [NumCnt-1:0] ovf_q;
  logic [NumCnt-1:0] ovf_d;
  logic [NumCnt-1:0] sat_new;

  logic              rd_valid_q;
  logic [CNT_W-1:0]  rd_data_q;

  // Per-cycle increment of each event counter.
  always_comb begin
    inc[0] = 2'd1;
    inc[1] = {1'b0, StallD};
    inc[2] = {1'b0, StallF & ~StallD};
    inc[3] = {1'b0, FlushE};
    inc[4] = {1'b0, FlushD};
    inc[5] = {1'b0, ForwardAE == 2'b10} + {1'b0, ForwardBE == 2'b10};
    inc[6] = {1'b0, ForwardAE == 2'b01} + {1'b0, ForwardBE == 2'b01};
    inc[7] = {1'b0, BranchTakenE};
  end

  // One extra sum bit so an increment of 2 from max-1 clamps instead of wrapping.
  always_comb begin
    for (int i = 0; i < NumCnt; i++) begin
      sum[i]     = {1'b0, cnt_q[i]} + (CNT_W + 1)'(inc[i]);
      cnt_d[i]   = cnt_q[i];
      ovf_d[i]   = ovf_q[i];
      sat_new[i] = 1'b0;
      if (Clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (state_q == StRun && !ovf_q[i]) begin
        if (sum[i] >= {1'b0, CntMax}) begin
          cnt_d[i]   = CntMax;
          ovf_d[i]   = 1'b1;
          sat_new[i] = 1'b1;
        end else begin
          cnt_d[i] = sum[i][CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumCnt; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
    if (reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // Running is registered alongside the state so it never glitches on decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Enable && !Clear) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (STOP_ON_OVF && (|sat_new)) begin
            state_q   <= StHalt;
            running_q <= 1'b0;
          end else if (!Enable) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end
        end
        StHalt: begin
          if (Clear) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Read returns the counter value from before this cycle's increment or Clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd.RdReq;
      if (rd.RdReq) begin
        rd_data_q <= cnt_q[rd.RdSel];
      end
    end
  end

  assign rd.RdValid = rd_valid_q;
  assign rd.RdData  = rd_data_q;
  assign Overflow   = ovf_q;
  assign Running    = running_q;

endmodule
